// File: rtl/decode_ctrl_regfile.sv
// Decode stage: bubble mux, instruction decoder, 2R/1W register file with write bypass.
// Optional load-use stall tracker is enabled by defining LOAD_USE_STALL_EN.
module decode_ctrl_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] addrD,
  input  logic [DATA_W-1:0] data_d,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] addrA,
  output logic [ADDR_W-1:0] addrB,
  output logic [ADDR_W-1:0] regD,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [1:0]        ALU_OP,
  output logic              is_immediate,
  output logic              is_branch,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic              MEM_TO_REG,
  output logic [DATA_W-1:0] imm,
  output logic              injecting_nop
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [DATA_W-1:0] regs_r [NREG];

`ifdef LOAD_USE_STALL_EN
  logic       lw_valid_r;
  logic [4:0] lw_rt_r;
  logic       uses_rt_s;

  // Remember the destination of a load that just left decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lw_valid_r <= 1'b0;
      lw_rt_r    <= 5'd0;
    end else begin
      lw_valid_r <= (instr_out[31:26] == OP_LW);
      lw_rt_r    <= instr_out[20:16];
    end
  end

  // Stall when the incoming instruction reads the pending load's target; a bubble clears the tracker.
  always_comb begin
    uses_rt_s     = 1'b0;
    injecting_nop = 1'b0;
    if ((instruction[31:26] == OP_RTYPE) || (instruction[31:26] == OP_SW) ||
        (instruction[31:26] == OP_BEQ)) begin
      uses_rt_s = 1'b1;
    end else begin
      uses_rt_s = 1'b0;
    end
    if (lw_valid_r && (lw_rt_r != 5'd0)) begin
      if (lw_rt_r == instruction[25:21]) begin
        injecting_nop = 1'b1;
      end else if (uses_rt_s && (lw_rt_r == instruction[20:16])) begin
        injecting_nop = 1'b1;
      end else begin
        injecting_nop = 1'b0;
      end
    end else begin
      injecting_nop = 1'b0;
    end
    instr_out = injecting_nop ? 32'h0000_0000 : instruction;
  end
`else
  // Stall logic absent: instructions pass straight through.
  always_comb begin
    injecting_nop = 1'b0;
    instr_out     = instruction;
  end
`endif

  assign op_s    = instr_out[31:26];
  assign funct_s = instr_out[5:0];
  assign addrA   = ADDR_W'(instr_out[25:21]);
  assign addrB   = ADDR_W'(instr_out[20:16]);
  assign regD    = (op_s == OP_RTYPE) ? ADDR_W'(instr_out[15:11]) : ADDR_W'(instr_out[20:16]);
  assign imm     = DATA_W'(instr_out[15:0]);

  // Control decode; anything unrecognised becomes a NOP with all flags low.
  always_comb begin
    ALU_OP       = 2'b00;
    is_immediate = 1'b0;
    is_branch    = 1'b0;
    WB_EN        = 1'b0;
    MEM_R_EN     = 1'b0;
    MEM_W_EN     = 1'b0;
    MEM_TO_REG   = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          6'h20:   begin ALU_OP = 2'b00; WB_EN = 1'b1; end
          6'h22:   begin ALU_OP = 2'b01; WB_EN = 1'b1; end
          6'h24:   begin ALU_OP = 2'b10; WB_EN = 1'b1; end
          6'h25:   begin ALU_OP = 2'b11; WB_EN = 1'b1; end
          default: begin ALU_OP = 2'b00; WB_EN = 1'b0; end
        endcase
      end
      OP_ADDI: begin
        is_immediate = 1'b1;
        WB_EN        = 1'b1;
      end
      OP_LW: begin
        is_immediate = 1'b1;
        MEM_R_EN     = 1'b1;
        MEM_TO_REG   = 1'b1;
        WB_EN        = 1'b1;
      end
      OP_SW: begin
        is_immediate = 1'b1;
        MEM_W_EN     = 1'b1;
      end
      OP_BEQ: begin
        is_branch = 1'b1;
        ALU_OP    = 2'b01;
      end
      default: begin
        ALU_OP = 2'b00;
      end
    endcase
  end

  // Register storage; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (is_write && (addrD != {ADDR_W{1'b0}})) begin
      regs_r[addrD] <= data_d;
    end else begin
      regs_r[0] <= {DATA_W{1'b0}};
    end
  end

  // Asynchronous reads with same-cycle write bypass.
  always_comb begin
    if (addrA == {ADDR_W{1'b0}}) begin
      data_a = {DATA_W{1'b0}};
    end else if (is_write && (addrA == addrD)) begin
      data_a = data_d;
    end else begin
      data_a = regs_r[addrA];
    end
    if (addrB == {ADDR_W{1'b0}}) begin
      data_b = {DATA_W{1'b0}};
    end else if (is_write && (addrB == addrD)) begin
      data_b = data_d;
    end else begin
      data_b = regs_r[addrB];
    end
  end

endmodule

// File: tb/tb_decode_ctrl_regfile.sv
// Self-checking bench for decode_ctrl_regfile: reference model plus directed literal checks.
module tb_decode_ctrl_regfile;

`ifdef LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        is_write = 1'b0;
  logic [4:0]  addrD = 5'd0;
  logic [31:0] data_d = 32'h0;
  logic [31:0] instr_out;
  logic [4:0]  addrA, addrB, regD;
  logic [31:0] data_a, data_b, imm;
  logic [1:0]  ALU_OP;
  logic        is_immediate, is_branch, WB_EN, MEM_R_EN, MEM_W_EN, MEM_TO_REG, injecting_nop;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  decode_ctrl_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .is_write(is_write),
    .addrD(addrD), .data_d(data_d), .instr_out(instr_out), .addrA(addrA),
    .addrB(addrB), .regD(regD), .data_a(data_a), .data_b(data_b), .ALU_OP(ALU_OP),
    .is_immediate(is_immediate), .is_branch(is_branch), .WB_EN(WB_EN),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .MEM_TO_REG(MEM_TO_REG),
    .imm(imm), .injecting_nop(injecting_nop)
  );

  always #5 clk = ~clk;

  // Reference model state: architectural registers and "last decoded op was a load".
  logic [31:0] mregs [32];
  logic        m_lw_valid;
  logic [4:0]  m_lw_rt;
  logic        exp_stall;
  logic [31:0] exp_io;

  always_comb begin
    exp_stall = STALL_EN && m_lw_valid && (m_lw_rt != 5'd0) &&
                ((m_lw_rt == instruction[25:21]) ||
                 (((instruction[31:26] == 6'h00) || (instruction[31:26] == 6'h2B) ||
                   (instruction[31:26] == 6'h04)) && (m_lw_rt == instruction[20:16])));
    exp_io = exp_stall ? 32'h0 : instruction;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mregs[i] <= 32'h0;
      m_lw_valid <= 1'b0;
      m_lw_rt    <= 5'd0;
    end else begin
      if (is_write && addrD != 5'd0) mregs[addrD] <= data_d;
      m_lw_valid <= (exp_io[31:26] == 6'h23);
      m_lw_rt    <= exp_io[20:16];
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (is_write && addrD == a) return data_d;
    return mregs[a];
  endfunction

  // Packed as {ALU_OP, is_immediate, is_branch, WB_EN, MEM_R_EN, MEM_W_EN, MEM_TO_REG}.
  function automatic logic [7:0] exp_ctrl(input logic [31:0] i);
    logic [5:0] op;
    logic [5:0] f;
    op = i[31:26];
    f  = i[5:0];
    if (op == 6'h00 && f == 6'h20) return 8'b00_001000;
    if (op == 6'h00 && f == 6'h22) return 8'b01_001000;
    if (op == 6'h00 && f == 6'h24) return 8'b10_001000;
    if (op == 6'h00 && f == 6'h25) return 8'b11_001000;
    if (op == 6'h08) return 8'b00_101000;
    if (op == 6'h23) return 8'b00_101101;
    if (op == 6'h2B) return 8'b00_100010;
    if (op == 6'h04) return 8'b01_010000;
    return 8'b00_000000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Compare every output against the model on each falling edge out of reset.
  always @(negedge clk) begin
    if (check_en && reset) begin
      chk("instr_out", instr_out, exp_io);
      chk("injecting_nop", {31'h0, injecting_nop}, {31'h0, exp_stall});
      chk("addrA", {27'h0, addrA}, {27'h0, exp_io[25:21]});
      chk("addrB", {27'h0, addrB}, {27'h0, exp_io[20:16]});
      chk("regD", {27'h0, regD}, {27'h0, (exp_io[31:26] == 6'h00) ? exp_io[15:11] : exp_io[20:16]});
      chk("data_a", data_a, exp_rd(exp_io[25:21]));
      chk("data_b", data_b, exp_rd(exp_io[20:16]));
      chk("ctrl", {24'h0, ALU_OP, is_immediate, is_branch, WB_EN, MEM_R_EN, MEM_W_EN, MEM_TO_REG},
          {24'h0, exp_ctrl(exp_io)});
      chk("imm", imm, {16'h0, exp_io[15:0]});
    end
  end

  // One cycle: drive after the rising edge, return just after the falling-edge compare.
  task automatic apply(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    instruction = ins;
    is_write    = we;
    addrD       = wa;
    data_d      = wd;
    @(negedge clk);
    #1;
  endtask

  logic [31:0] table_v [8] = '{32'hAC43_0004, 32'h1043_0002, 32'h0043_2024, 32'h0043_2025,
                               32'h0043_2026, 32'hFC43_2025, 32'h8C43_0000, 32'h2083_0010};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b1;
    check_en = 1'b1;

    // Reset contents: every register reads zero.
    for (int i = 1; i < 32; i++) begin
      logic [4:0] a;
      a = i[4:0];
      apply({6'h00, a, ~a, 5'd1, 5'd0, 6'h20}, 1'b0, 5'd0, 32'h0);
      chk("reset_data_a", data_a, 32'h0);
    end
    chk("reset_inj", {31'h0, injecting_nop}, 32'h0);

    apply(32'h0, 1'b1, 5'd5, 32'h1234_5678);
    apply({6'h00, 5'd5, 5'd0, 5'd1, 5'd0, 6'h20}, 1'b0, 5'd0, 32'h0);
    chk("r5_read", data_a, 32'h1234_5678);
    apply({6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20}, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("r0_bypass", data_a, 32'h0);
    apply({6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20}, 1'b0, 5'd0, 32'h0);
    chk("r0_after", data_a, 32'h0);

    apply({6'h00, 5'd5, 5'd7, 5'd1, 5'd0, 6'h20}, 1'b1, 5'd7, 32'hA5A5_A5A5);
    chk("bypass_b", data_b, 32'hA5A5_A5A5);
    chk("bypass_a_r5", data_a, 32'h1234_5678);

    apply(32'h00A6_3822, 1'b0, 5'd0, 32'h0);
    chk("sub_aluop", {30'h0, ALU_OP}, 32'h1);
    chk("sub_regD", {27'h0, regD}, 32'd7);
    chk("sub_wb", {31'h0, WB_EN}, 32'h1);
    chk("sub_imm_flag", {31'h0, is_immediate}, 32'h0);

    apply(32'h2008_FFFF, 1'b0, 5'd0, 32'h0);
    chk("addi_imm", imm, 32'h0000_FFFF);
    chk("addi_flag", {31'h0, is_immediate}, 32'h1);
    chk("addi_regD", {27'h0, regD}, 32'd8);

    // Fill registers with distinct values, then sweep the decode table.
    for (int i = 1; i < 32; i++) begin
      logic [4:0] a;
      a = i[4:0];
      apply({6'h00, a, ~a, 5'd2, 5'd0, 6'h22}, 1'b1, a, (32'h0101_0101 * i) ^ 32'hDEAD_BEEF);
    end
    for (int i = 0; i < 8; i++) apply(table_v[i], 1'b0, 5'd0, 32'h0);

    // Load-use: LW rt=3 then ADD rs=3 held by fetch for two cycles.
    apply(32'h8C03_0000, 1'b0, 5'd0, 32'h0);
    apply(32'h0064_2020, 1'b0, 5'd0, 32'h0);
    chk("lu_inj", {31'h0, injecting_nop}, {31'h0, STALL_EN});
    chk("lu_instr", instr_out, STALL_EN ? 32'h0 : 32'h0064_2020);
    apply(32'h0064_2020, 1'b0, 5'd0, 32'h0);
    chk("lu_release", {31'h0, injecting_nop}, 32'h0);
    chk("lu_pass", instr_out, 32'h0064_2020);

    // rt-only dependence: stalls for SW, not for ADDI; rt=0 never stalls.
    apply(32'h8C03_0000, 1'b0, 5'd0, 32'h0);
    apply(32'hAC43_0004, 1'b0, 5'd0, 32'h0);
    chk("sw_dep", {31'h0, injecting_nop}, {31'h0, STALL_EN});
    apply(32'hAC43_0004, 1'b0, 5'd0, 32'h0);
    apply(32'h8C03_0000, 1'b0, 5'd0, 32'h0);
    apply(32'h2043_0001, 1'b0, 5'd0, 32'h0);
    chk("addi_no_dep", {31'h0, injecting_nop}, 32'h0);
    apply(32'h8C00_0000, 1'b0, 5'd0, 32'h0);
    apply(32'h0000_0020, 1'b0, 5'd0, 32'h0);
    chk("rt0_no_dep", {31'h0, injecting_nop}, 32'h0);

    // Reset mid-stall aborts the bubble; writes during reset are dropped.
    apply(32'h8C03_0000, 1'b0, 5'd0, 32'h0);
    apply(32'h0064_2020, 1'b0, 5'd0, 32'h0);
    reset    = 1'b0;
    is_write = 1'b1;
    addrD    = 5'd9;
    data_d   = 32'hCAFE_F00D;
    #1;
    chk("rst_abort_inj", {31'h0, injecting_nop}, 32'h0);
    chk("rst_abort_instr", instr_out, 32'h0064_2020);
    chk("rst_r3_zero", data_a, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    is_write = 1'b0;
    reset    = 1'b1;
    apply({6'h00, 5'd9, 5'd5, 5'd1, 5'd0, 6'h20}, 1'b0, 5'd0, 32'h0);
    chk("rst_write_dropped", data_a, 32'h0);
    chk("rst_r5_cleared", data_b, 32'h0);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
